// File: rtl/psum_accum.sv
`default_nettype none
// ============================================================================
//  Module   : psum_accum
//  Purpose  : Sums per-macro 4-bit signed partial sums for each channel, then
//             accumulates the result with saturation over a programmable number
//             of passes. Each result is handed downstream on a valid/ready
//             handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module psum_accum #(
    parameter int CHANNEL_NUM = 128,
    parameter int MACRO_NUM   = 4,
    parameter int OUT_WIDTH   = 16,
    parameter int PASS_WIDTH  = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [CHANNEL_NUM-1:0][MACRO_NUM-1:0][3:0] data_in,
    input  logic [PASS_WIDTH-1:0]                   pass_num,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [CHANNEL_NUM-1:0][OUT_WIDTH-1:0]   data_out,
    output logic [CHANNEL_NUM-1:0]                  sat_flag
);

    // Width of the macro-adder result (6 bits for four macros: -32..28).
    // MACRO_NUM is assumed to be at least 2.
    localparam int c_S1_W = 4 + $clog2(MACRO_NUM);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACC   = 2'd1,
        S_FLUSH = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [PASS_WIDTH-1:0] r_cnt;
    logic [PASS_WIDTH-1:0] r_pass;
    logic                  r_s1_valid;
    logic                  w_accept;
    logic                  w_release;
    logic [PASS_WIDTH-1:0] w_pass_eff;
    logic [PASS_WIDTH-1:0] w_cnt_inc;

    assign w_accept   = in_valid && in_ready;
    assign w_release  = (r_state == S_OUT) && out_ready;
    // A pass count of zero behaves as a single pass.
    assign w_pass_eff = (pass_num == '0) ? PASS_WIDTH'(1) : pass_num;
    assign w_cnt_inc  = r_cnt + PASS_WIDTH'(1);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = (w_pass_eff == PASS_WIDTH'(1)) ? S_FLUSH : S_ACC;
                end
            end
            S_ACC: begin
                in_ready = 1'b1;
                if (in_valid && (w_cnt_inc == r_pass)) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // Last stage-1 value drains into the accumulator this cycle.
                w_state_nxt = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Beat counter, latched pass count and stage-1 valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_pass     <= '0;
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_release) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                if (r_state == S_IDLE) begin
                    r_cnt  <= PASS_WIDTH'(1);
                    r_pass <= w_pass_eff;
                end else begin
                    r_cnt <= w_cnt_inc;
                end
            end
        end
    end

    for (genvar c = 0; c < CHANNEL_NUM; c++) begin : g_ch
        logic [c_S1_W-1:0]    w_sum;
        logic [c_S1_W-1:0]    r_s1;
        logic [OUT_WIDTH:0]   w_tot;
        logic [OUT_WIDTH-1:0] w_acc_nxt;
        logic [OUT_WIDTH-1:0] r_acc;
        logic                 r_sat;
        logic                 w_clamp;

        // Macro adder: sign-extend each decoded nibble and sum across macros.
        always_comb begin
            w_sum = '0;
            for (int m = 0; m < MACRO_NUM; m++) begin
                w_sum = w_sum + {{(c_S1_W-4){data_in[c][m][3]}}, data_in[c][m]};
            end
        end

        // Stage-1 register loads only on an accepted beat.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_s1 <= '0;
            end else if (w_accept) begin
                r_s1 <= w_sum;
            end
        end

        // One guard bit detects overflow of the signed accumulator add.
        assign w_tot   = {r_acc[OUT_WIDTH-1], r_acc}
                       + {{(OUT_WIDTH+1-c_S1_W){r_s1[c_S1_W-1]}}, r_s1};
        assign w_clamp = w_tot[OUT_WIDTH] ^ w_tot[OUT_WIDTH-1];

        // Clamp to the most negative / most positive representable value.
        always_comb begin
            w_acc_nxt = w_tot[OUT_WIDTH-1:0];
            if (w_clamp) begin
                w_acc_nxt = w_tot[OUT_WIDTH] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                             : {1'b0, {(OUT_WIDTH-1){1'b1}}};
            end
        end

        // Accumulator and sticky saturation flag, cleared when the result is taken.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_acc <= '0;
                r_sat <= 1'b0;
            end else if (w_release) begin
                r_acc <= '0;
                r_sat <= 1'b0;
            end else if (r_s1_valid) begin
                r_acc <= w_acc_nxt;
                if (w_clamp) begin
                    r_sat <= 1'b1;
                end
            end
        end

        assign data_out[c] = r_acc;
        assign sat_flag[c] = r_sat;
    end

endmodule
`default_nettype wire

// File: tb/tb_psum_accum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_psum_accum
//  Purpose  : Self-checking bench for psum_accum. A wide instance (16-bit
//             results) and a narrow instance (8-bit results, 8 channels) run in
//             lockstep on shared stimulus and are compared to an arithmetic
//             model of the accumulate-and-clamp rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_psum_accum;

    localparam int CH  = 128;
    localparam int MN  = 4;
    localparam int OW  = 16;
    localparam int PW  = 8;
    localparam int CH8 = 8;
    localparam int OW8 = 8;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     in_valid;
    logic                     out_ready;
    logic [PW-1:0]            pass_num;
    logic [CH-1:0][MN-1:0][3:0] data_in;
    logic                     in_ready;
    logic                     out_valid;
    logic [CH-1:0][OW-1:0]    data_out;
    logic [CH-1:0]            sat_flag;
    logic                     in_ready8;
    logic                     out_valid8;
    logic [CH8-1:0][OW8-1:0]  data_out8;
    logic [CH8-1:0]           sat_flag8;

    int n_cmp  = 0;
    int n_fail = 0;

    int m_acc  [CH];
    bit m_sat  [CH];
    int m_acc8 [CH8];
    bit m_sat8 [CH8];

    always #5 clk = ~clk;

    psum_accum #(
        .CHANNEL_NUM(CH), .MACRO_NUM(MN), .OUT_WIDTH(OW), .PASS_WIDTH(PW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .pass_num(pass_num),
        .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .sat_flag(sat_flag)
    );

    psum_accum #(
        .CHANNEL_NUM(CH8), .MACRO_NUM(MN), .OUT_WIDTH(OW8), .PASS_WIDTH(PW)
    ) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready8),
        .data_in(data_in[CH8-1:0]), .pass_num(pass_num),
        .out_valid(out_valid8), .out_ready(out_ready),
        .data_out(data_out8), .sat_flag(sat_flag8)
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    // Reference: per beat, add the signed channel sum and clamp to the result range.
    task automatic model_beat();
        int s;
        int t;
        for (int c = 0; c < CH; c++) begin
            s = 0;
            for (int m = 0; m < MN; m++) s += int'($signed(data_in[c][m]));
            t = m_acc[c] + s;
            if (t > 32767)       begin t = 32767;  m_sat[c] = 1'b1; end
            else if (t < -32768) begin t = -32768; m_sat[c] = 1'b1; end
            m_acc[c] = t;
            if (c < CH8) begin
                t = m_acc8[c] + s;
                if (t > 127)       begin t = 127;  m_sat8[c] = 1'b1; end
                else if (t < -128) begin t = -128; m_sat8[c] = 1'b1; end
                m_acc8[c] = t;
            end
        end
    endtask

    // mode 0: every nibble = v; mode 1: (c+m)%16; otherwise random.
    task automatic fill(input int mode, input logic [3:0] v);
        for (int c = 0; c < CH; c++)
            for (int m = 0; m < MN; m++)
                case (mode)
                    0:       data_in[c][m] = v;
                    1:       data_in[c][m] = 4'((c + m) % 16);
                    default: data_in[c][m] = 4'($urandom);
                endcase
    endtask

    task automatic check_results(input string tag);
        for (int c = 0; c < CH; c++) begin
            check($sformatf("%s.d16[%0d]", tag, c), $signed(data_out[c]), m_acc[c]);
            check($sformatf("%s.s16[%0d]", tag, c), {31'b0, sat_flag[c]}, {31'b0, m_sat[c]});
        end
        for (int c = 0; c < CH8; c++) begin
            check($sformatf("%s.d8[%0d]", tag, c), $signed(data_out8[c]), m_acc8[c]);
            check($sformatf("%s.s8[%0d]", tag, c), {31'b0, sat_flag8[c]}, {31'b0, m_sat8[c]});
        end
    endtask

    // One full group: beats (optionally with idle gaps), flush, output hold, handshake.
    task automatic run_group(input string tag, input int pn, input int mode,
                             input logic [3:0] v, input bit gaps, input int hold);
        int np;
        np = (pn == 0) ? 1 : pn;
        for (int c = 0; c < CH; c++) begin m_acc[c] = 0; m_sat[c] = 1'b0; end
        for (int c = 0; c < CH8; c++) begin m_acc8[c] = 0; m_sat8[c] = 1'b0; end
        pass_num = PW'(pn);
        for (int b = 0; b < np; b++) begin
            if (gaps && b > 0) begin
                in_valid = 1'b0;
                fill(2, 4'h0);
                @(negedge clk);
            end
            fill(mode, v);
            in_valid = 1'b1;
            check({tag, ".in_ready"}, {31'b0, in_ready}, 1);
            model_beat();
            @(negedge clk);
            pass_num = PW'($urandom);
        end
        // Beats offered during FLUSH/OUT must be ignored.
        in_valid = 1'b1;
        fill(2, 4'h0);
        check({tag, ".flush_ready"}, {31'b0, in_ready}, 0);
        check({tag, ".flush_valid"}, {31'b0, out_valid}, 0);
        @(negedge clk);
        check({tag, ".out_valid"}, {31'b0, out_valid}, 1);
        check({tag, ".out_valid8"}, {31'b0, out_valid8}, 1);
        check({tag, ".out_ready_in"}, {31'b0, in_ready}, 0);
        check_results(tag);
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            @(negedge clk);
            check({tag, ".hold_valid"}, {31'b0, out_valid}, 1);
            check({tag, ".hold_in_ready"}, {31'b0, in_ready}, 0);
            check_results({tag, ".hold"});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({tag, ".post_valid"}, {31'b0, out_valid}, 0);
        check({tag, ".post_in_ready"}, {31'b0, in_ready}, 1);
        check({tag, ".post_data"}, {31'b0, |data_out}, 0);
        check({tag, ".post_sat"}, {31'b0, |sat_flag}, 0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        pass_num  = '0;
        data_in   = '0;
        repeat (2) @(negedge clk);
        check("rst.in_ready", {31'b0, in_ready}, 1);
        check("rst.out_valid", {31'b0, out_valid}, 0);
        check("rst.data_out", {31'b0, |data_out}, 0);
        check("rst.sat_flag", {31'b0, |sat_flag}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle.in_ready", {31'b0, in_ready}, 1);

        run_group("p7x9", 9, 0, 4'h7, 1'b0, 0);
        run_group("m8x3", 3, 0, 4'h8, 1'b0, 0);
        run_group("m8x0", 0, 0, 4'h8, 1'b0, 0);
        run_group("pat4", 4, 1, 4'h0, 1'b1, 0);
        run_group("hold", 3, 2, 4'h0, 1'b0, 10);
        run_group("sat8", 5, 0, 4'h7, 1'b0, 0);
        run_group("zero", 2, 0, 4'h0, 1'b0, 0);

        // Asynchronous reset after two of four beats.
        pass_num = 8'd4;
        in_valid = 1'b1;
        fill(2, 4'h0);
        @(negedge clk);
        fill(2, 4'h0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst.out_valid", {31'b0, out_valid}, 0);
        check("arst.in_ready", {31'b0, in_ready}, 1);
        check("arst.data_out", {31'b0, |data_out}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_group("after_rst", 4, 0, 4'h1, 1'b0, 0);

        run_group("long", 40, 2, 4'h0, 1'b0, 0);
        for (int k = 0; k < 6; k++) begin
            run_group($sformatf("rnd%0d", k), $urandom_range(0, 12), 2, 4'h0,
                      1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
